// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, width helpers and parity function for the UART receive path
//
// Build option: UART_RX_PARITY_EN adds the PARITY state (one even-parity bit per frame).
package uart_pkg;

  localparam int MAX_DATA_BITS  = 9;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } rx_state_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Value the parity bit must carry so the ones count (data + parity) is even.
  function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - consumer-side bus of the UART receive FIFO
//
// master: consumer (drives rd_en, err_clr)
// slave : uart_rx_fifo (drives rd_data, empty, full, count, frame_err, overrun, parity_err)
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  logic                                 rd_en;
  logic [DATA_BITS-1:0]                 rd_data;
  logic                                 empty;
  logic                                 full;
  logic [count_width(FIFO_DEPTH)-1:0]   count;
  logic                                 frame_err;
  logic                                 overrun;
  logic                                 parity_err;
  logic                                 err_clr;

  modport master (
    output rd_en, err_clr,
    input  rd_data, empty, full, count, frame_err, overrun, parity_err
  );

  modport slave (
    input  rd_en, err_clr,
    output rd_data, empty, full, count, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO, power-of-two depth
//
// Ports: clk, rst_n (async, active-low), push/push_data (write), pop (ignored
// when empty), head (current entry, 0 when empty), empty, full, count.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_BITS,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic [WIDTH-1:0]                push_data,
  input  logic                            pop,
  output logic [WIDTH-1:0]                head,
  output logic                            empty,
  output logic                            full,
  output logic [count_width(DEPTH)-1:0]   count
);
  localparam int AW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with oversample tick generator, error flags and receive FIFO
//
// Ports: clk, rst_n (async, active-low), rx (async serial line, idle high),
// bus (uart_rx_fifo_if.slave: rd_en, err_clr in; rd_data, empty, full, count,
// frame_err, overrun, parity_err out).
// Build option: UART_RX_PARITY_EN enables one even-parity bit per frame.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  uart_rx_fifo_if.slave   bus
);
  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  logic rx_meta, rx_s;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  assign tick = (div_cnt == DIV_W'(DIV - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  rx_state_t            state, state_n;
  logic [SW-1:0]        s_cnt, s_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 push, set_fe, set_ov;
  logic                 fe_q, ov_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_n;
  logic                 set_pe;
  logic                 pe_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      s_cnt   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      s_cnt   <= s_cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  // Data bits are sampled OVERSAMPLE ticks apart starting from the start-bit
  // mid-point, so every later sample also lands mid-bit.
  always_comb begin
    state_n   = state;
    s_cnt_n   = s_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    push      = 1'b0;
    set_fe    = 1'b0;
    set_ov    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    set_pe    = 1'b0;
`endif
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_n = ST_START;
            s_cnt_n = '0;
          end
        end
        ST_START: begin
          if (s_cnt == S_MID) begin
            s_cnt_n   = '0;
            bit_cnt_n = '0;
            state_n   = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (s_cnt == S_LAST) begin
            s_cnt_n   = '0;
            shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt_n = bit_cnt + 1'b1;
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (s_cnt == S_LAST) begin
            s_cnt_n   = '0;
            par_bad_n = (rx_s != even_parity(MAX_DATA_BITS'(shreg)));
            state_n   = ST_STOP;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (s_cnt == S_LAST) begin
            s_cnt_n = '0;
            state_n = ST_IDLE;
            if (!rx_s) set_fe = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (par_bad) set_pe = 1'b1;
            if (rx_s && !par_bad) begin
`else
            if (rx_s) begin
`endif
              if (!bus.full || bus.rd_en) push   = 1'b1;
              else                        set_ov = 1'b1;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // A new error in the err_clr cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fe_q <= 1'b0;
      ov_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q <= 1'b0;
`endif
    end else begin
      fe_q <= set_fe | (fe_q & ~bus.err_clr);
      ov_q <= set_ov | (ov_q & ~bus.err_clr);
`ifdef UART_RX_PARITY_EN
      pe_q <= set_pe | (pe_q & ~bus.err_clr);
`endif
    end
  end

  assign bus.frame_err  = fe_q;
  assign bus.overrun    = ov_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = pe_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .pop       (bus.rd_en),
    .head      (bus.rd_data),
    .empty     (bus.empty),
    .full      (bus.full),
    .count     (bus.count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed table-driven bench for uart_rx_fifo (16 clocks per bit)
module tb_uart_rx_fifo;
  localparam int BIT_CYC = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus ();

  uart_rx_fifo #(
    .CLK_HZ     (1_600_000),
    .BAUD       (100_000),
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .FIFO_DEPTH (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pop_after;
    logic       clr_after;
    int         exp_count;
    logic [7:0] exp_head;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_cyc(BIT_CYC);
  endtask

  // par_bit is only transmitted in the parity build.
  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop);
    @(negedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
`else
    if (par_bit === 1'bx) rx = 1'b1;
`endif
    send_bit(stop);
    rx = 1'b1;
    wait_cyc(20);
  endtask

  task automatic pop1();
    bus.rd_en = 1'b1;
    wait_cyc(1);
    bus.rd_en = 1'b0;
  endtask

  task automatic clr1();
    bus.err_clr = 1'b1;
    wait_cyc(1);
    bus.err_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b1};
    vecs[2] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1, 8'h5A, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 1'b0, 2, 8'h5A, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 2, 8'h81, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 2, 8'h81, 1'b1};

    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    wait_cyc(3);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    check("rst_flags", {29'd0, bus.frame_err, bus.overrun, bus.parity_err}, 0);
    rst_n = 1'b1;
    wait_cyc(5);

    rx = 1'b0;
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(40);
    check("glitch_count", 32'(bus.count), 0);
    check("glitch_flags", {29'd0, bus.frame_err, bus.overrun, bus.parity_err}, 0);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, ^vecs[v].data, vecs[v].stop);
      check($sformatf("v%0d_count", v), 32'(bus.count), 32'(vecs[v].exp_count));
      check($sformatf("v%0d_head", v), 32'(bus.rd_data), 32'(vecs[v].exp_head));
      check($sformatf("v%0d_empty", v), 32'(bus.empty), 32'(vecs[v].exp_count == 0));
      check($sformatf("v%0d_frame_err", v), 32'(bus.frame_err), 32'(vecs[v].exp_fe));
      if (vecs[v].pop_after) pop1();
      if (vecs[v].clr_after) clr1();
    end
    clr1();
    check("fe_cleared", 32'(bus.frame_err), 0);
    pop1();
    check("drain_head_ff", 32'(bus.rd_data), 32'h0FF);
    pop1();
    check("drain_empty", 32'(bus.empty), 1);
    check("drain_rd_data_zero", 32'(bus.rd_data), 0);

    for (int i = 0; i < 17; i++) send_frame(8'(i), ^(8'(i)), 1'b1);
    check("ovr_full", 32'(bus.full), 1);
    check("ovr_count", 32'(bus.count), 16);
    check("ovr_flag", 32'(bus.overrun), 1);
    check("ovr_head", 32'(bus.rd_data), 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovr_pop%0d", i), 32'(bus.rd_data), 32'(i));
      pop1();
    end
    check("ovr_drained", 32'(bus.empty), 1);
    clr1();
    check("ovr_cleared", 32'(bus.overrun), 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    check("par_bad_flag", 32'(bus.parity_err), 1);
    check("par_bad_count", 32'(bus.count), 0);
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_ok_count", 32'(bus.count), 1);
    check("par_ok_head", 32'(bus.rd_data), 32'h07);
    check("par_ok_flag_kept", 32'(bus.parity_err), 1);
    pop1();
    clr1();
    check("par_cleared", 32'(bus.parity_err), 0);
`endif

    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    send_frame(8'h33, ^8'h33, 1'b1);
    send_frame(8'h44, ^8'h44, 1'b0);
    check("pre_rst_count", 32'(bus.count), 3);
    check("pre_rst_fe", 32'(bus.frame_err), 1);
    @(negedge clk);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_cyc(5);
    rst_n = 1'b0;
    rx    = 1'b1;
    wait_cyc(3);
    check("mid_rst_count", 32'(bus.count), 0);
    check("mid_rst_empty", 32'(bus.empty), 1);
    check("mid_rst_flags", {29'd0, bus.frame_err, bus.overrun, bus.parity_err}, 0);
    rst_n = 1'b1;
    wait_cyc(20);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    check("post_rst_count", 32'(bus.count), 1);
    check("post_rst_head", 32'(bus.rd_data), 32'h5A);
    check("post_rst_fe", 32'(bus.frame_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
